// File: rtl/session_access_controller.sv
`default_nettype none
// ============================================================================
//  Module      : session_access_controller
//  Description : Button/switch front end: sync + debounce, login, feature
//                grant/deny, logout, idle timeout and failed-login lockout.
//  Revision    : 1.0 - initial release
// ============================================================================
module session_access_controller #(
    parameter int DEB_CYCLES  = 4,
    parameter int TIMEOUT     = 1000,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 500
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic [3:0] CH,
    input  logic       BT0,
    input  logic       BT1,
    output logic [3:0] AT,
    output logic [6:0] FT,
    output logic       DENY,
    output logic       LOCKED
);

    localparam int c_DW   = $clog2(DEB_CYCLES + 1);
    localparam int c_TMAX = (TIMEOUT > LOCK_CYCLES) ? TIMEOUT : LOCK_CYCLES;
    localparam int c_TW   = $clog2(c_TMAX + 1);
    localparam int c_FW   = $clog2(MAX_FAIL + 1);

    localparam logic [c_DW-1:0] c_DEB_LAST  = c_DW'(DEB_CYCLES - 1);
    localparam logic [c_DW-1:0] c_DEB_MAX   = c_DW'(DEB_CYCLES);
    localparam logic [c_TW-1:0] c_TO_LAST   = c_TW'(TIMEOUT - 1);
    localparam logic [c_TW-1:0] c_LK_LAST   = c_TW'(LOCK_CYCLES - 1);
    localparam logic [c_FW-1:0] c_FAIL_LAST = c_FW'(MAX_FAIL - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SESSION = 2'd1;
    localparam logic [1:0] S_LOCKOUT = 2'd2;

    logic [3:0]      r_ch_s1, r_ch_s2;
    logic [1:0]      r_bt_s1, r_bt_s2;
    logic [1:0]      r_p_prev;
    logic [c_DW-1:0] r_deb_cnt;
    logic            r_released;

    logic [1:0]      r_state, w_state_nxt;
    logic [3:0]      r_at, w_at_nxt;
    logic [6:0]      r_ft, w_ft_nxt;
    logic            r_deny, w_deny_nxt;
    logic            r_locked;
    logic [c_FW-1:0] r_fail, w_fail_nxt;
    logic [c_TW-1:0] r_timer, w_timer_nxt;

    logic [1:0]      w_p;
    logic            w_stable;
    logic            w_evt;
    logic [3:0]      w_login;
    logic [2:0]      w_code;
    logic [2:0]      w_max_idx;
    logic            w_perm;
    logic [6:0]      w_ft_hot;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_ch_s1 <= '0;
            r_ch_s2 <= '0;
            r_bt_s1 <= '0;
            r_bt_s2 <= '0;
        end else begin
            r_ch_s1 <= CH;
            r_ch_s2 <= r_ch_s1;
            r_bt_s1 <= {BT0, BT1};
            r_bt_s2 <= r_bt_s1;
        end
    end

    assign w_p      = r_bt_s2;
    assign w_stable = (w_p == r_p_prev) && (r_deb_cnt == c_DEB_LAST);
    // Only a press that follows a full release counts as a command.
    assign w_evt    = w_stable && (w_p != 2'b00) && r_released;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_p_prev   <= '0;
            r_deb_cnt  <= '0;
            r_released <= 1'b1;
        end else begin
            r_p_prev <= w_p;
            if (w_p != r_p_prev)
                r_deb_cnt <= '0;
            else if (r_deb_cnt != c_DEB_MAX)
                r_deb_cnt <= r_deb_cnt + c_DW'(1);
            if (w_stable) begin
                if (w_p == 2'b00)
                    r_released <= 1'b1;
                else if (r_released)
                    r_released <= 1'b0;
            end
        end
    end

    always_comb begin
        w_login = 4'b0000;
        case ({r_ch_s2[0], w_p})
            3'b1_01: w_login = 4'b1000;
            3'b0_11: w_login = 4'b0100;
            3'b0_01: w_login = 4'b0010;
            3'b1_10: w_login = 4'b0001;
            default: w_login = 4'b0000;
        endcase
    end

    assign w_code = r_ch_s2[3:1];

    always_comb begin
        w_max_idx = 3'd0;
        if (r_at[3])
            w_max_idx = 3'd6;
        else if (r_at[2])
            w_max_idx = 3'd5;
        else if (r_at[1])
            w_max_idx = 3'd3;
    end

    assign w_perm   = (w_code != 3'd0) && ((w_code - 3'd1) <= w_max_idx);
    assign w_ft_hot = 7'd1 << (w_code - 3'd1);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_evt) begin
                    if (w_login != 4'b0000)
                        w_state_nxt = S_SESSION;
                    else if (r_fail == c_FAIL_LAST)
                        w_state_nxt = S_LOCKOUT;
                end
            end
            S_SESSION: begin
                if (w_evt) begin
                    if (w_p == 2'b01)
                        w_state_nxt = S_IDLE;
                end else if (r_timer == c_TO_LAST) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LOCKOUT: begin
                if (r_timer == c_LK_LAST)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_at_nxt    = r_at;
        w_ft_nxt    = r_ft;
        w_deny_nxt  = 1'b0;
        w_fail_nxt  = r_fail;
        w_timer_nxt = r_timer + c_TW'(1);
        case (r_state)
            S_IDLE: begin
                w_at_nxt    = 4'b0000;
                w_ft_nxt    = 7'b0000000;
                w_timer_nxt = '0;
                if (w_evt) begin
                    if (w_login != 4'b0000) begin
                        w_at_nxt   = w_login;
                        w_fail_nxt = '0;
                    end else begin
                        w_deny_nxt = 1'b1;
                        w_fail_nxt = r_fail + c_FW'(1);
                    end
                end
            end
            S_SESSION: begin
                if (w_evt) begin
                    w_timer_nxt = '0;
                    if (w_p == 2'b10) begin
                        if (w_code == 3'd0)
                            w_ft_nxt = 7'b0000000;
                        else if (w_perm)
                            w_ft_nxt = w_ft_hot;
                        else
                            w_deny_nxt = 1'b1;
                    end else if (w_p == 2'b01) begin
                        w_at_nxt = 4'b0000;
                        w_ft_nxt = 7'b0000000;
                    end
                end else if (r_timer == c_TO_LAST) begin
                    w_at_nxt    = 4'b0000;
                    w_ft_nxt    = 7'b0000000;
                    w_timer_nxt = '0;
                end
            end
            S_LOCKOUT: begin
                w_at_nxt = 4'b0000;
                w_ft_nxt = 7'b0000000;
                if (r_timer == c_LK_LAST) begin
                    w_timer_nxt = '0;
                    w_fail_nxt  = '0;
                end
            end
            default: begin
                w_at_nxt    = 4'b0000;
                w_ft_nxt    = 7'b0000000;
                w_timer_nxt = '0;
                w_fail_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_at     <= '0;
            r_ft     <= '0;
            r_deny   <= 1'b0;
            r_locked <= 1'b0;
            r_fail   <= '0;
            r_timer  <= '0;
        end else begin
            r_at     <= w_at_nxt;
            r_ft     <= w_ft_nxt;
            r_deny   <= w_deny_nxt;
            r_locked <= (w_state_nxt == S_LOCKOUT);
            r_fail   <= w_fail_nxt;
            r_timer  <= w_timer_nxt;
        end
    end

    assign AT     = r_at;
    assign FT     = r_ft;
    assign DENY   = r_deny;
    assign LOCKED = r_locked;

endmodule
`default_nettype wire
